// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 vector pipeline: opcodes, vector geometry
// and the memory-stage FSM state type.
package cvp14_pkg;

  localparam int VLEN   = 16;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = $clog2(VLEN) + 1;

  localparam logic [3:0] OP_VADD  = 4'b0000;
  localparam logic [3:0] OP_VSUB  = 4'b0001;
  localparam logic [3:0] OP_VMUL  = 4'b0010;
  localparam logic [3:0] OP_VDOT  = 4'b0011;
  localparam logic [3:0] OP_VLD   = 4'b0100;
  localparam logic [3:0] OP_VST   = 4'b0101;
  localparam logic [3:0] OP_VSPLT = 4'b0110;
  localparam logic [3:0] OP_ADD   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_AND   = 4'b1001;
  localparam logic [3:0] OP_OR    = 4'b1010;
  localparam logic [3:0] OP_XOR   = 4'b1011;
  localparam logic [3:0] OP_SLL   = 4'b1100;
  localparam logic [3:0] OP_SRL   = 4'b1101;
  localparam logic [3:0] OP_SLH   = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/vector_mem_stage.sv
// Vector load/store stage: moves one VLEN-element vector between the pipeline
// and a narrow data memory, one element per acknowledged memory transaction.
module vector_mem_stage
  import cvp14_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               opcode,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [VLEN*ELEM_W-1:0]   st_vec,
  output logic                     busy,
  output logic                     done,
  output logic [VLEN*ELEM_W-1:0]   ld_vec,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [ELEM_W-1:0]        mem_wdata,
  input  logic [ELEM_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  mem_state_e               state_r, state_nxt_s;
  logic [IDX_W-1:0]         idx_r, idx_nxt_s;
  logic [ADDR_W-1:0]        base_r, base_nxt_s;
  logic                     is_ld_r, is_ld_nxt_s;
  logic [VLEN*ELEM_W-1:0]   st_vec_r, st_vec_nxt_s;
  logic [VLEN*ELEM_W-1:0]   ld_vec_r;
  logic                     accept_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic                     mem_rd_r, mem_rd_s;
  logic                     mem_wr_r, mem_wr_s;
  logic [ADDR_W-1:0]        mem_addr_r, mem_addr_s;
  logic [ELEM_W-1:0]        mem_wdata_r, mem_wdata_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && (opcode == OP_VLD || opcode == OP_VST)) begin
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        if (mem_ack && idx_r == IDX_W'(VLEN - 1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output comb: computes next-cycle values so every port is driven from a flop
  always_comb begin
    accept_s     = 1'b0;
    idx_nxt_s    = idx_r;
    base_nxt_s   = base_r;
    is_ld_nxt_s  = is_ld_r;
    st_vec_nxt_s = st_vec_r;
    if (state_r == IDLE && state_nxt_s == XFER) begin
      accept_s     = 1'b1;
      idx_nxt_s    = {IDX_W{1'b0}};
      base_nxt_s   = addr;
      is_ld_nxt_s  = (opcode == OP_VLD);
      st_vec_nxt_s = st_vec;
    end else if (state_r == XFER && mem_ack) begin
      idx_nxt_s = idx_r + IDX_W'(1'b1);
    end else begin
      idx_nxt_s = idx_r;
    end

    busy_s = (state_nxt_s != IDLE);
    done_s = (state_nxt_s == DONE);
    if (state_nxt_s == XFER) begin
      mem_rd_s    = is_ld_nxt_s;
      mem_wr_s    = !is_ld_nxt_s;
      mem_addr_s  = base_nxt_s + {{(ADDR_W-IDX_W){1'b0}}, idx_nxt_s};
      mem_wdata_s = is_ld_nxt_s ? {ELEM_W{1'b0}}
                                : st_vec_nxt_s[idx_nxt_s[IDX_W-2:0]*ELEM_W +: ELEM_W];
    end else begin
      mem_rd_s    = 1'b0;
      mem_wr_s    = 1'b0;
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {ELEM_W{1'b0}};
    end
  end

  // Transfer context, load assembly and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r       <= {IDX_W{1'b0}};
      base_r      <= {ADDR_W{1'b0}};
      is_ld_r     <= 1'b0;
      st_vec_r    <= {(VLEN*ELEM_W){1'b0}};
      ld_vec_r    <= {(VLEN*ELEM_W){1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {ELEM_W{1'b0}};
    end else begin
      idx_r       <= idx_nxt_s;
      base_r      <= base_nxt_s;
      is_ld_r     <= is_ld_nxt_s;
      st_vec_r    <= st_vec_nxt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      mem_rd_r    <= mem_rd_s;
      mem_wr_r    <= mem_wr_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if (accept_s && opcode == OP_VLD) begin
        ld_vec_r <= {(VLEN*ELEM_W){1'b0}};
      end else if (state_r == XFER && mem_ack && is_ld_r) begin
        ld_vec_r[idx_r[IDX_W-2:0]*ELEM_W +: ELEM_W] <= mem_rdata;
      end else begin
        ld_vec_r <= ld_vec_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign ld_vec    = ld_vec_r;
  assign mem_addr  = mem_addr_r;
  assign mem_rd    = mem_rd_r;
  assign mem_wr    = mem_wr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_vector_mem_stage.sv
// Directed + randomized bench for vector_mem_stage against a behavioural
// memory/vector model.
module tb_vector_mem_stage;
  import cvp14_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   opcode;
  logic [15:0]  addr;
  logic [255:0] st_vec;
  logic         busy, done;
  logic [255:0] ld_vec;
  logic [15:0]  mem_addr;
  logic         mem_rd, mem_wr;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_ack;

  logic [15:0]  mem [0:65535];
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  vector_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .addr(addr),
    .st_vec(st_vec), .busy(busy), .done(done), .ld_vec(ld_vec),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One vector transfer, responding as the memory and checking every cycle
  task automatic run_op(input logic [3:0] op, input logic [15:0] base,
                        input logic [255:0] sv, input bit stalls, input bit inject);
    logic [255:0] exp_ld, prev_ld;
    logic [15:0]  ea, a;
    int           nel, stall_left, total_stall, done_cyc;
    bit           is_ld;
    is_ld   = (op == OP_VLD);
    prev_ld = ld_vec;
    for (int i = 0; i < 16; i++) begin
      a = base + 16'(i);
      exp_ld[i*16 +: 16] = mem[a];
    end
    nel = 0; total_stall = 0; done_cyc = -1;
    stall_left = stalls ? int'($urandom_range(0, 3)) : 0;
    @(negedge clk);
    start = 1'b1; opcode = op; addr = base; st_vec = sv; mem_ack = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 120 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start  = (inject && cyc == 5);
      opcode = OP_VLD;
      addr   = 16'h5555;
      st_vec = ~sv;
      if (done) begin
        done_cyc = cyc;
        chk("done_strobes", {254'd0, mem_rd, mem_wr}, 256'd0);
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
      end else begin
        ea = base + 16'(nel);
        chk("busy_xfer", {255'd0, busy}, 256'd1);
        chk("strobe", {254'd0, mem_rd, mem_wr}, is_ld ? 256'd2 : 256'd1);
        chk("mem_addr", {240'd0, mem_addr}, {240'd0, ea});
        if (!is_ld) chk("mem_wdata", {240'd0, mem_wdata}, {240'd0, sv[nel*16 +: 16]});
        if (stall_left > 0) begin
          mem_ack = 1'b0; stall_left--; total_stall++;
        end else begin
          mem_ack = 1'b1;
          stall_left = stalls ? int'($urandom_range(0, 3)) : 0;
        end
        mem_rdata = mem[mem_addr];
        if (mem_ack) begin
          if (!is_ld) mem[mem_addr] = mem_wdata;
          nel++;
        end
      end
    end
    chk("done_latency", 256'(done_cyc), 256'(17 + total_stall));
    chk("elem_count", 256'(nel), 256'd16);
    chk("ld_vec", ld_vec, is_ld ? exp_ld : prev_ld);
    @(negedge clk);
    chk("idle_after", {254'd0, busy, done}, 256'd0);
  endtask

  initial begin
    logic [255:0] sv;
    rst_n = 1'b0; start = 1'b0; opcode = OP_NOP; addr = 16'h0000;
    st_vec = 256'd0; mem_rdata = 16'h0000; mem_ack = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'hA000 + 16'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {252'd0, busy, done, mem_rd, mem_wr}, 256'd0);
    chk("rst_addr", {224'd0, mem_addr, mem_wdata}, 256'd0);
    chk("rst_ld", ld_vec, 256'd0);
    rst_n = 1'b1;

    // Basic load, ack tied high
    run_op(OP_VLD, 16'h0100, 256'd0, 1'b0, 1'b0);
    chk("ld_e0", {240'd0, ld_vec[15:0]}, {240'd0, 16'hA000});
    chk("ld_e15", {240'd0, ld_vec[255:240]}, {240'd0, 16'hA00F});

    // Store with ascending pattern; last element is 0xFFFF
    for (int i = 0; i < 16; i++) sv[i*16 +: 16] = 16'(16'h1111 * i);
    run_op(OP_VST, 16'h0200, sv, 1'b0, 1'b0);
    chk("st_last", {240'd0, mem[16'h020F]}, {240'd0, 16'hFFFF});

    // Address wrap at top of memory
    run_op(OP_VLD, 16'hFFFA, 256'd0, 1'b0, 1'b0);

    // Start mid-transfer must be ignored
    run_op(OP_VLD, 16'h0400, 256'd0, 1'b0, 1'b1);

    // Non-memory opcode in IDLE ignored
    @(negedge clk); start = 1'b1; opcode = OP_VADD; addr = 16'h0700;
    @(negedge clk); start = 1'b0;
    repeat (20) begin
      chk("vadd_ignored", {252'd0, busy, done, mem_rd, mem_wr}, 256'd0);
      @(negedge clk);
    end

    // Random transfers with random ack stalls
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 8; j++) sv[j*32 +: 32] = $urandom;
      run_op(($urandom_range(0, 1) == 0) ? OP_VLD : OP_VST, 16'($urandom), sv, 1'b1, 1'b0);
    end

    // Reset in the middle of a load
    @(negedge clk); start = 1'b1; opcode = OP_VLD; addr = 16'h0300; mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_addr", {240'd0, mem_addr}, {240'd0, 16'h0307});
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {252'd0, busy, done, mem_rd, mem_wr}, 256'd0);
    chk("midrst_addr", {240'd0, mem_addr}, 256'd0);
    chk("midrst_ld", ld_vec, 256'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(OP_VLD, 16'h0300, 256'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
